// File: rtl/branch_target_buffer_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// PC slicing helpers.
package branch_target_buffer_pkg;
   typedef logic [1:0] ctr_t;

   localparam ctr_t SNT       = 2'b00;
   localparam ctr_t WNT       = 2'b01;
   localparam ctr_t WT        = 2'b10;
   localparam ctr_t ST        = 2'b11;
   localparam ctr_t CTR_RESET = WNT;

   // Word index into the table; callers truncate to idx_w bits.
   function automatic logic [31:0] pc_index(input logic [31:0] pc, input int idx_w);
      return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
   endfunction

   // Upper address bits above the index; callers truncate to 30-idx_w bits.
   function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction
endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
   import branch_target_buffer_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       inc,
   output logic [1:0] nxt
);
   always_comb begin
      nxt = ctr;
      if (inc) begin
         if (ctr != ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != SNT) nxt = ctr - 2'd1;
      end
   end
endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit direction counters: combinational IF lookup,
// training from the resolved EX branch, and branch/mispredict counters.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int   IDX_W     = 6,
   parameter ctr_t CTR_ALLOC = 2'b10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] PC_IF,
   output logic [31:0] PredictPC,
   output logic        PredictF,
   output logic        PredictPCValid,
   input  logic        upd_valid,
   input  logic        upd_is_br,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred,
   output logic        mispredict,
   output logic [31:0] br_cnt,
   output logic [31:0] miss_cnt
);
   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic [N-1:0]        valid_q;
   ctr_t [N-1:0]        ctr_q;
   logic [TAG_W-1:0]    tag_mem [N];
   logic [31:0]         tgt_mem [N];

   logic [IDX_W-1:0] l_idx, u_idx;
   logic [TAG_W-1:0] l_tag, u_tag;
   logic             l_hit, u_hit, upd;
   ctr_t             ctr_nxt;

   assign l_idx = IDX_W'(pc_index(PC_IF, IDX_W));
   assign l_tag = TAG_W'(pc_tag(PC_IF, IDX_W));
   assign u_idx = IDX_W'(pc_index(upd_pc, IDX_W));
   assign u_tag = TAG_W'(pc_tag(upd_pc, IDX_W));

   // Lookup reads pre-update contents; no write-to-read bypass.
   assign l_hit = rst_n && valid_q[l_idx] && (tag_mem[l_idx] == l_tag);
   assign u_hit = valid_q[u_idx] && (tag_mem[u_idx] == u_tag);
   assign upd   = upd_valid && upd_is_br;

   assign PredictPCValid = l_hit;
   assign PredictF       = l_hit && ctr_q[l_idx][1];
   assign PredictPC      = l_hit ? tgt_mem[l_idx] : 32'h0;
   assign mispredict     = rst_n && upd && (upd_taken ^ upd_pred);

   sat_counter2 u_ctr (
      .ctr (ctr_q[u_idx]),
      .inc (upd_taken),
      .nxt (ctr_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= '0;
         ctr_q    <= {N{CTR_RESET}};
         br_cnt   <= 32'd0;
         miss_cnt <= 32'd0;
      end else begin
         if (upd) begin
            br_cnt <= br_cnt + 32'd1;
            if (u_hit) begin
               ctr_q[u_idx] <= ctr_nxt;
            end else if (upd_taken) begin
               valid_q[u_idx] <= 1'b1;
               ctr_q[u_idx]   <= CTR_ALLOC;
            end
         end
         if (mispredict) miss_cnt <= miss_cnt + 32'd1;
      end
   end

   // Tag/target carry no reset; a cleared valid bit makes stale data harmless.
   always_ff @(posedge clk) begin
      if (rst_n && upd && upd_taken) begin
         tag_mem[u_idx] <= u_tag;
         tgt_mem[u_idx] <= upd_target;
      end
   end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_branch_target_buffer;
   logic        clk, rst_n;
   logic [31:0] PC_IF, PredictPC, upd_pc, upd_target, br_cnt, miss_cnt;
   logic        PredictF, PredictPCValid, upd_valid, upd_is_br, upd_taken, upd_pred, mispredict;

   int checks = 0;
   int failures = 0;

   // Reference model: 64 entries, index = word address mod 64, tag = pc / 256.
   bit          m_valid [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   logic [31:0] e_br, e_miss;

   branch_target_buffer dut (
      .clk(clk), .rst_n(rst_n), .PC_IF(PC_IF), .PredictPC(PredictPC),
      .PredictF(PredictF), .PredictPCValid(PredictPCValid),
      .upd_valid(upd_valid), .upd_is_br(upd_is_br), .upd_pc(upd_pc),
      .upd_taken(upd_taken), .upd_target(upd_target), .upd_pred(upd_pred),
      .mispredict(mispredict), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int idx_of(logic [31:0] pc);
      return int'((pc >> 2) % 64);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == (pc >> 8));
   endfunction

   function automatic logic [33:0] exp_look(logic [31:0] pc);
      bit h;
      h = m_hit(pc);
      return {h, h && (m_ctr[idx_of(pc)] >= 2), h ? m_tgt[idx_of(pc)] : 32'h0};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0;
         m_ctr[i]   = 1;
      end
      e_br = 0;
      e_miss = 0;
   endtask

   task automatic model_apply();
      int i;
      i = idx_of(upd_pc);
      if (m_hit(upd_pc)) begin
         if (upd_taken) begin
            m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = upd_target;
         end else begin
            m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
         end
      end else if (upd_taken) begin
         m_valid[i] = 1;
         m_tag[i]   = upd_pc >> 8;
         m_tgt[i]   = upd_target;
         m_ctr[i]   = 2;
      end
      e_br = e_br + 1;
      if (upd_taken != upd_pred) e_miss = e_miss + 1;
   endtask

   task automatic drive(logic [31:0] pc, logic taken, logic [31:0] tgt, logic pred);
      @(negedge clk);
      upd_valid = 1; upd_is_br = 1; upd_pc = pc;
      upd_taken = taken; upd_target = tgt; upd_pred = pred;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n && upd_valid && upd_is_br) model_apply();
      #1;
      upd_valid = 0;
   endtask

   task automatic test_reset();
      rst_n = 0; PC_IF = 32'h100;
      upd_valid = 0; upd_is_br = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_pred = 0;
      model_reset();
      #2;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== 34'h0) begin
         failures++; $display("FAIL reset_look_held got=%h exp=0", {PredictPCValid, PredictF, PredictPC});
      end
      @(negedge clk);
      rst_n = 1;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== 34'h0) begin
         failures++; $display("FAIL reset_look got=%h exp=0", {PredictPCValid, PredictF, PredictPC});
      end
      checks++;
      if (br_cnt !== 0 || miss_cnt !== 0) begin
         failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", br_cnt, miss_cnt);
      end
   endtask

   task automatic test_alloc();
      drive(32'h100, 1, 32'h80, 0);
      PC_IF = 32'h100;
      #1;
      checks++;
      if (mispredict !== 1'b1) begin
         failures++; $display("FAIL alloc_mispredict got=%b exp=1", mispredict);
      end
      step();
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== {2'b11, 32'h80}) begin
         failures++; $display("FAIL alloc_look got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, {2'b11, 32'h80});
      end
      checks++;
      if (br_cnt !== 1 || miss_cnt !== 1) begin
         failures++; $display("FAIL alloc_counts got=%0d/%0d exp=1/1", br_cnt, miss_cnt);
      end
   endtask

   task automatic test_not_taken();
      // ctr path: 10->01->00->00, then up to 11 and held, then back down.
      bit tk [9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
      bit ef [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      logic [33:0] l;
      for (int k = 0; k < 9; k++) begin
         l = exp_look(32'h100);
         drive(32'h100, tk[k], 32'h80, l[32]);
         step();
         PC_IF = 32'h100;
         #1;
         checks++;
         if ({PredictPCValid, PredictF, PredictPC} !== {1'b1, ef[k], 32'h80}) begin
            failures++; $display("FAIL ctr_train_%0d got=%h exp=%h", k, {PredictPCValid, PredictF, PredictPC}, {1'b1, ef[k], 32'h80});
         end
      end
   endtask

   task automatic test_alias();
      drive(32'h200, 1, 32'h40, 0);
      step();
      PC_IF = 32'h100;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== 34'h0) begin
         failures++; $display("FAIL alias_old_miss got=%h exp=0", {PredictPCValid, PredictF, PredictPC});
      end
      PC_IF = 32'h200;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== {2'b11, 32'h40}) begin
         failures++; $display("FAIL alias_new_hit got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, {2'b11, 32'h40});
      end
   endtask

   task automatic test_same_cycle();
      drive(32'h300, 1, 32'h1234_5670, 0);
      PC_IF = 32'h200;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== {2'b11, 32'h40}) begin
         failures++; $display("FAIL same_cycle_old_hit got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, {2'b11, 32'h40});
      end
      PC_IF = 32'h300;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== 34'h0) begin
         failures++; $display("FAIL same_cycle_no_bypass got=%h exp=0", {PredictPCValid, PredictF, PredictPC});
      end
      step();
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== {2'b11, 32'h1234_5670}) begin
         failures++; $display("FAIL same_cycle_next got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, {2'b11, 32'h1234_5670});
      end
   endtask

   task automatic test_stall();
      logic [31:0] b0, m0;
      b0 = e_br; m0 = e_miss;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         upd_valid = 0; upd_is_br = 1; upd_pc = 32'h300;
         upd_taken = 0; upd_target = 32'hdead_0000; upd_pred = 1;
         #1;
         checks++;
         if (mispredict !== 1'b0) begin
            failures++; $display("FAIL stall_mispredict_%0d got=%b exp=0", k, mispredict);
         end
         step();
      end
      PC_IF = 32'h300;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== {2'b11, 32'h1234_5670}) begin
         failures++; $display("FAIL stall_look got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, {2'b11, 32'h1234_5670});
      end
      checks++;
      if (br_cnt !== b0 || miss_cnt !== m0) begin
         failures++; $display("FAIL stall_counts got=%0d/%0d exp=%0d/%0d", br_cnt, miss_cnt, b0, m0);
      end
   endtask

   function automatic logic [31:0] rnd_pc();
      // Small tag/index pool so hits, aliasing and saturation all occur.
      return ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
   endfunction

   task automatic test_random();
      logic [33:0] ex;
      logic        em;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         upd_valid  = ($urandom_range(0, 3) != 0);
         upd_is_br  = ($urandom_range(0, 3) != 0);
         upd_pc     = rnd_pc();
         upd_taken  = $urandom_range(0, 1);
         upd_pred   = $urandom_range(0, 1);
         upd_target = $urandom;
         PC_IF      = ($urandom_range(0, 1) != 0) ? upd_pc : rnd_pc();
         #1;
         ex = exp_look(PC_IF);
         em = upd_valid && upd_is_br && (upd_taken != upd_pred);
         checks++;
         if ({PredictPCValid, PredictF, PredictPC} !== ex) begin
            failures++; $display("FAIL rand_look_%0d pc=%h got=%h exp=%h", n, PC_IF, {PredictPCValid, PredictF, PredictPC}, ex);
         end
         checks++;
         if (mispredict !== em) begin
            failures++; $display("FAIL rand_mispredict_%0d got=%b exp=%b", n, mispredict, em);
         end
         step();
         if (n % 50 == 49) begin
            checks++;
            if (br_cnt !== e_br || miss_cnt !== e_miss) begin
               failures++; $display("FAIL rand_counts_%0d got=%0d/%0d exp=%0d/%0d", n, br_cnt, miss_cnt, e_br, e_miss);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      drive(32'h400, 1, 32'hABC0, 0);
      step();
      @(negedge clk);
      upd_valid = 1; upd_is_br = 1; upd_pc = 32'h400;
      upd_taken = 1; upd_target = 32'h5550; upd_pred = 0;
      PC_IF = 32'h400;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== exp_look(32'h400)) begin
         failures++; $display("FAIL areset_pre got=%h exp=%h", {PredictPCValid, PredictF, PredictPC}, exp_look(32'h400));
      end
      rst_n = 0;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC, mispredict} !== 35'h0) begin
         failures++; $display("FAIL areset_outputs got=%h exp=0", {PredictPCValid, PredictF, PredictPC, mispredict});
      end
      checks++;
      if (br_cnt !== 0 || miss_cnt !== 0) begin
         failures++; $display("FAIL areset_counts got=%0d/%0d exp=0/0", br_cnt, miss_cnt);
      end
      @(posedge clk);
      #1;
      model_reset();
      @(negedge clk);
      upd_valid = 0;
      rst_n = 1;
      #1;
      checks++;
      if ({PredictPCValid, PredictF, PredictPC} !== 34'h0) begin
         failures++; $display("FAIL areset_empty got=%h exp=0", {PredictPCValid, PredictF, PredictPC});
      end
      checks++;
      if (br_cnt !== 0 || miss_cnt !== 0) begin
         failures++; $display("FAIL areset_counts_after got=%0d/%0d exp=0/0", br_cnt, miss_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_alloc();
      test_not_taken();
      test_alias();
      test_same_cycle();
      test_stall();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
